// File: rtl/bpm_pkg.sv
// Shared types and helpers for the BPM calculator slice.
package bpm_pkg;

    typedef enum logic [0:0] {
        S_WAIT_FIRST = 1'b0,
        S_TRACK      = 1'b1
    } fsm_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_RUN  = 2'd1,
        D_DONE = 2'd2
    } div_state_t;

    // Bits needed to hold the numerator 60*fs.
    function automatic int calc_num_w(input int fs);
        return $clog2(60 * fs + 1);
    endfunction

endpackage

// File: rtl/bpm_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, saturating quotient.
// The first quotient bit is resolved while loading, so NUM_W bits take NUM_W cycles.
module bpm_seq_divider
    import bpm_pkg::*;
#(
    parameter int NUM_W = 13,
    parameter int DEN_W = 10,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quot
);

    localparam int CNT_BITS = $clog2(NUM_W + 1);
    localparam logic [CNT_BITS-1:0] STEPS_AFTER_LOAD = CNT_BITS'(NUM_W - 1);
    localparam logic [CNT_BITS-1:0] LAST_STEP        = CNT_BITS'(1);
    localparam logic [NUM_W-1:0]    Q_SAT            = NUM_W'((1 << Q_W) - 1);

    div_state_t          state_r;
    logic [DEN_W-1:0]    rem_r;
    logic [DEN_W-1:0]    den_r;
    logic [NUM_W-1:0]    q_r;
    logic [CNT_BITS-1:0] step_cnt_r;
    logic                busy_r;
    logic [DEN_W+NUM_W-1:0] step_s;
    logic [DEN_W+NUM_W-1:0] load_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [DEN_W+NUM_W-1:0] div_step(
        input logic [DEN_W-1:0] rem,
        input logic [NUM_W-1:0] q,
        input logic [DEN_W-1:0] d
    );
        logic [DEN_W:0] trial;
        logic [DEN_W:0] diff;
        trial = {rem, q[NUM_W-1]};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d}) begin
            return {DEN_W'(diff), q[NUM_W-2:0], 1'b1};
        end else begin
            return {DEN_W'(trial), q[NUM_W-2:0], 1'b0};
        end
    endfunction

    // Next-step values for the running iteration and for a fresh load.
    always_comb begin
        step_s = div_step(rem_r, q_r, den_r);
        load_s = div_step({DEN_W{1'b0}}, num, den);
        if (q_r > Q_SAT) begin
            quot = Q_W'(Q_SAT);
        end else begin
            quot = Q_W'(q_r);
        end
    end

    // Divider sequencer: load, iterate, present result for one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r    <= D_IDLE;
            rem_r      <= {DEN_W{1'b0}};
            den_r      <= {DEN_W{1'b0}};
            q_r        <= {NUM_W{1'b0}};
            step_cnt_r <= {CNT_BITS{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                D_IDLE: begin
                    if (start) begin
                        {rem_r, q_r} <= load_s;
                        den_r        <= den;
                        step_cnt_r   <= STEPS_AFTER_LOAD;
                        busy_r       <= 1'b1;
                        state_r      <= D_RUN;
                    end
                end
                D_RUN: begin
                    {rem_r, q_r} <= step_s;
                    step_cnt_r   <= step_cnt_r - LAST_STEP;
                    if (step_cnt_r == LAST_STEP) begin
                        state_r <= D_DONE;
                    end
                end
                D_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= D_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= D_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = (state_r == D_DONE);

endmodule

// File: rtl/bpm_calculator.sv
// Peak-interval averaging and 60*FS/avg BPM computation.
// Optional feature macro: BPM_TIMEOUT_EN (no-pulse timeout back to S_WAIT_FIRST).
module bpm_calculator
    import bpm_pkg::*;
#(
    parameter int FS           = 125,
    parameter int CNT_W        = 10,
    parameter int AVG_LOG2     = 2,
    parameter int BPM_W        = 8,
    parameter int MIN_INTERVAL = 30,
    parameter int MAX_INTERVAL = 375
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             peak_in,
    output logic [BPM_W-1:0] bpm_out,
    output logic             bpm_valid,
    output logic             busy,
    output logic             no_pulse
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int NUM_W = calc_num_w(FS);
    localparam int SUM_W = CNT_W + AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic [NUM_W-1:0] NUM_C     = NUM_W'(60 * FS);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_INTERVAL);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [FW-1:0]    FILL_NEAR = FW'(N - 1);
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1);

    if (MAX_INTERVAL >= (1 << CNT_W)) begin : g_bad_max_interval
        $error("MAX_INTERVAL must be below 2**CNT_W");
    end

    fsm_state_t          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    ring_r [N];
    logic [AVG_LOG2-1:0] wr_ptr_r;
    logic [SUM_W-1:0]    sum_r;
    logic [FW-1:0]       fill_r;
    logic                push_r;
    logic [CNT_W-1:0]    new_int_r;
    logic                start_r;
    logic [BPM_W-1:0]    bpm_out_r;
    logic                bpm_valid_r;
    logic                no_pulse_r;

    logic                peak_ok_s;
    logic                first_s;
    logic                accept_s;
    logic                timeout_s;
    logic [CNT_W-1:0]    reload_s;
    logic                div_busy_s;
    logic                div_done_s;
    logic [BPM_W-1:0]    div_quot_s;

    // Peak classification and timeout detection.
    always_comb begin
        peak_ok_s = en & peak_in;
        reload_s  = {{(CNT_W-1){1'b0}}, valid_in};
        if (peak_ok_s && state_r == S_WAIT_FIRST) begin
            first_s  = 1'b1;
            accept_s = 1'b0;
        end else if (peak_ok_s && cnt_r >= MIN_C) begin
            first_s  = 1'b0;
            accept_s = 1'b1;
        end else begin
            first_s  = 1'b0;
            accept_s = 1'b0;
        end
`ifdef BPM_TIMEOUT_EN
        if (en && state_r == S_TRACK && cnt_r >= CNT_W'(MAX_INTERVAL)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
`else
        timeout_s = 1'b0;
`endif
    end

    // Accept at E, commit history at E+1, kick the divider so it loads at E+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_WAIT_FIRST;
            cnt_r       <= {CNT_W{1'b0}};
            wr_ptr_r    <= {AVG_LOG2{1'b0}};
            sum_r       <= {SUM_W{1'b0}};
            fill_r      <= {FW{1'b0}};
            push_r      <= 1'b0;
            new_int_r   <= {CNT_W{1'b0}};
            start_r     <= 1'b0;
            bpm_out_r   <= {BPM_W{1'b0}};
            bpm_valid_r <= 1'b0;
            no_pulse_r  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                ring_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            push_r      <= 1'b0;
            start_r     <= 1'b0;
            bpm_valid_r <= 1'b0;
            if (en && valid_in && cnt_r != CNT_SAT) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (timeout_s) begin
                state_r     <= S_WAIT_FIRST;
                wr_ptr_r    <= {AVG_LOG2{1'b0}};
                sum_r       <= {SUM_W{1'b0}};
                fill_r      <= {FW{1'b0}};
                no_pulse_r  <= 1'b1;
                bpm_out_r   <= {BPM_W{1'b0}};
                bpm_valid_r <= 1'b1;
                for (int i = 0; i < N; i++) begin
                    ring_r[i] <= {CNT_W{1'b0}};
                end
            end else begin
                if (first_s || accept_s) begin
                    cnt_r <= reload_s;
                end
                if (first_s) begin
                    state_r <= S_TRACK;
                end
                if (accept_s) begin
                    push_r     <= 1'b1;
                    new_int_r  <= cnt_r;
                    no_pulse_r <= 1'b0;
                end
                if (push_r) begin
                    ring_r[wr_ptr_r] <= new_int_r;
                    sum_r    <= sum_r - SUM_W'(ring_r[wr_ptr_r]) + SUM_W'(new_int_r);
                    wr_ptr_r <= wr_ptr_r + 1'b1;
                    if (fill_r != FILL_FULL) begin
                        fill_r <= fill_r + FILL_ONE;
                    end
                    start_r <= (fill_r >= FILL_NEAR) && !div_busy_s;
                end
                if (div_done_s) begin
                    bpm_out_r   <= div_quot_s;
                    bpm_valid_r <= 1'b1;
                end
            end
        end
    end

    bpm_seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W),
        .Q_W   (BPM_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .flush (timeout_s),
        .start (start_r),
        .num   (NUM_C),
        .den   (sum_r[SUM_W-1:AVG_LOG2]),
        .busy  (div_busy_s),
        .done  (div_done_s),
        .quot  (div_quot_s)
    );

    assign bpm_out   = bpm_out_r;
    assign bpm_valid = bpm_valid_r;
    assign busy      = div_busy_s;
    assign no_pulse  = no_pulse_r;

endmodule

// File: tb/tb_bpm_calculator.sv
// Directed bench for bpm_calculator; a second instance with a short MIN_INTERVAL
// covers saturation and peaks accepted while the divider is busy.
module tb_bpm_calculator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       valid_in = 1'b0;
    logic       peak_in = 1'b0;
    logic [7:0] bpm_out, f_bpm_out;
    logic       bpm_valid, busy, no_pulse;
    logic       f_bpm_valid, f_busy, f_no_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int peak_cyc = 0;
    int v_cnt = 0;
    int v_cyc = 0;
    int f_cnt = 0;
    logic [7:0] v_bpm = 8'd0;
    logic [7:0] f_bpm = 8'd0;

    bpm_calculator dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .peak_in(peak_in),
        .bpm_out(bpm_out), .bpm_valid(bpm_valid), .busy(busy), .no_pulse(no_pulse)
    );

    bpm_calculator #(.MIN_INTERVAL(8)) dut_fast (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .peak_in(peak_in),
        .bpm_out(f_bpm_out), .bpm_valid(f_bpm_valid), .busy(f_busy), .no_pulse(f_no_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bpm_valid === 1'b1) begin
            v_cnt = v_cnt + 1;
            v_bpm = bpm_out;
            v_cyc = cyc;
        end
        if (f_bpm_valid === 1'b1) begin
            f_cnt = f_cnt + 1;
            f_bpm = f_bpm_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        valid_in = 1'b1;
        peak_in  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic peak();
        valid_in = 1'b0;
        peak_in  = 1'b1;
        tick();
        peak_cyc = cyc;
        peak_in  = 1'b0;
        valid_in = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        peak_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bpm_out !== 8'd0) begin errors++; $display("FAIL reset_bpm_out: got %0d expected 0", bpm_out); end
        checks++; if (bpm_valid !== 1'b0) begin errors++; $display("FAIL reset_bpm_valid: got %b expected 0", bpm_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (no_pulse !== 1'b0) begin errors++; $display("FAIL reset_no_pulse: got %b expected 0", no_pulse); end
        checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL reset_fast_busy: got %b expected 0", f_busy); end
        rst = 1'b0;
    endtask

    task automatic test_first_fill();
        int base;
        do_reset();
        base = v_cnt;
        peak();
        repeat (3) begin gap(100); peak(); end
        gap(100);
        checks++; if (v_cnt !== base) begin errors++; $display("FAIL fill_no_early_valid: got %0d strobes expected 0", v_cnt - base); end
        peak();
        gap(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b expected 1", busy); end
        gap(15);
        checks++; if (v_cnt !== base + 1) begin errors++; $display("FAIL fill_strobes: got %0d expected 1", v_cnt - base); end
        checks++; if (v_bpm !== 8'd75) begin errors++; $display("FAIL fill_bpm: got %0d expected 75", v_bpm); end
        checks++; if (v_cyc - peak_cyc !== 15) begin errors++; $display("FAIL fill_latency: got %0d expected 15", v_cyc - peak_cyc); end
        checks++; if (bpm_out !== 8'd75) begin errors++; $display("FAIL fill_hold: got %0d expected 75", bpm_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_average();
        int base;
        do_reset();
        base = v_cnt;
        peak();
        gap(100); peak();
        gap(100); peak();
        gap(120); peak();
        gap(80);  peak();
        gap(20);
        checks++; if (v_cnt !== base + 1) begin errors++; $display("FAIL avg_first_strobe: got %0d expected 1", v_cnt - base); end
        checks++; if (v_bpm !== 8'd75) begin errors++; $display("FAIL avg_first_bpm: got %0d expected 75", v_bpm); end
        gap(105); peak();
        gap(20);
        checks++; if (v_cnt !== base + 2) begin errors++; $display("FAIL avg_second_strobe: got %0d expected 2", v_cnt - base); end
        checks++; if (v_bpm !== 8'd70) begin errors++; $display("FAIL avg_second_bpm: got %0d expected 70", v_bpm); end
    endtask

    // Continues from test_average: 20 strobes have passed since the last accepted peak.
    task automatic test_reject();
        int base;
        base = v_cnt;
        peak();
        gap(80); peak();
        gap(20);
        checks++; if (v_cnt !== base + 1) begin errors++; $display("FAIL reject_strobes: got %0d expected 1", v_cnt - base); end
        checks++; if (v_bpm !== 8'd70) begin errors++; $display("FAIL reject_bpm: got %0d expected 70", v_bpm); end
    endtask

    task automatic test_saturation();
        int base;
        do_reset();
        base = f_cnt;
        peak();
        repeat (4) begin gap(10); peak(); end
        gap(20);
        checks++; if (f_cnt !== base + 1) begin errors++; $display("FAIL sat_strobes: got %0d expected 1", f_cnt - base); end
        checks++; if (f_bpm !== 8'd255) begin errors++; $display("FAIL sat_bpm: got %0d expected 255", f_bpm); end
    endtask

    task automatic test_accept_while_busy();
        int base;
        do_reset();
        base = f_cnt;
        peak();
        repeat (4) begin gap(40); peak(); end
        gap(10); peak();
        checks++; if (f_busy !== 1'b1) begin errors++; $display("FAIL busy_at_peak: got %b expected 1", f_busy); end
        gap(10);
        checks++; if (f_cnt !== base + 1) begin errors++; $display("FAIL busy_single_strobe: got %0d expected 1", f_cnt - base); end
        checks++; if (f_bpm !== 8'd187) begin errors++; $display("FAIL busy_first_bpm: got %0d expected 187", f_bpm); end
        gap(30); peak();
        gap(20);
        checks++; if (f_cnt !== base + 2) begin errors++; $display("FAIL busy_next_strobe: got %0d expected 2", f_cnt - base); end
        checks++; if (f_bpm !== 8'd234) begin errors++; $display("FAIL busy_history_bpm: got %0d expected 234", f_bpm); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        peak();
        repeat (4) begin gap(100); peak(); end
        gap(20);
        gap(80); peak();
        gap(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (bpm_out !== 8'd0) begin errors++; $display("FAIL midrst_bpm_out: got %0d expected 0", bpm_out); end
        base = v_cnt;
        gap(20);
        checks++; if (v_cnt !== base) begin errors++; $display("FAIL midrst_aborted: got %0d strobes expected 0", v_cnt - base); end
        peak();
        repeat (3) begin gap(100); peak(); end
        gap(100);
        checks++; if (v_cnt !== base) begin errors++; $display("FAIL midrst_refill: got %0d strobes expected 0", v_cnt - base); end
        peak();
        gap(20);
        checks++; if (v_cnt !== base + 1) begin errors++; $display("FAIL midrst_resume_strobe: got %0d expected 1", v_cnt - base); end
        checks++; if (v_bpm !== 8'd75) begin errors++; $display("FAIL midrst_resume_bpm: got %0d expected 75", v_bpm); end
    endtask

    // Continues from test_mid_reset: tracking with bpm_out 75.
    task automatic test_timeout();
        int base;
        base = v_cnt;
        gap(400);
`ifdef BPM_TIMEOUT_EN
        checks++; if (no_pulse !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", no_pulse); end
        checks++; if (bpm_out !== 8'd0) begin errors++; $display("FAIL timeout_bpm_out: got %0d expected 0", bpm_out); end
        checks++; if (v_cnt !== base + 1) begin errors++; $display("FAIL timeout_strobe: got %0d expected 1", v_cnt - base); end
        peak();
        repeat (4) begin gap(125); peak(); end
        gap(20);
        checks++; if (v_bpm !== 8'd60) begin errors++; $display("FAIL timeout_recover_bpm: got %0d expected 60", v_bpm); end
        checks++; if (no_pulse !== 1'b0) begin errors++; $display("FAIL timeout_flag_clear: got %b expected 0", no_pulse); end
        checks++; if (v_cnt !== base + 2) begin errors++; $display("FAIL timeout_recover_strobes: got %0d expected 2", v_cnt - base); end
`else
        checks++; if (no_pulse !== 1'b0) begin errors++; $display("FAIL notimeout_flag: got %b expected 0", no_pulse); end
        checks++; if (bpm_out !== 8'd75) begin errors++; $display("FAIL notimeout_hold: got %0d expected 75", bpm_out); end
        checks++; if (v_cnt !== base) begin errors++; $display("FAIL notimeout_strobes: got %0d expected 0", v_cnt - base); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_fill();
        test_average();
        test_reject();
        test_saturation();
        test_accept_while_busy();
        test_mid_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpm_calculator.md
# bpm_calculator

Converts the single-cycle `peak_detected` pulses from the peak detector into a beats-per-minute value. Sits directly downstream of the peak detector, on the same `valid_in` sample strobe. It measures peak-to-peak intervals in valid samples, averages the last 2^AVG_LOG2 accepted intervals, and divides `60*FS` by that average with a sequential divider. It emits `bpm_out` with a one-cycle `bpm_valid` strobe for the display/UART stage.

## Interface
- `FS`, 125: sample rate in Hz of `valid_in` strobes; numerator constant NUM = 60*FS
- `CNT_W`, 10: interval counter width
- `AVG_LOG2`, 2: log2 of averaging depth N (default 4)
- `BPM_W`, 8: output width
- `MIN_INTERVAL`, 30: shortest accepted interval in samples (250 BPM)
- `MAX_INTERVAL`, 375: timeout interval in samples (20 BPM); must be < 2^CNT_W
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: block enable
- `valid_in` in 1: sample strobe, same as the peak detector's
- `peak_in` in 1: `peak_detected` from the peak detector, single-cycle pulse
- `bpm_out` out BPM_W: last computed BPM, held between updates
- `bpm_valid` out 1: one-cycle strobe when `bpm_out` updates
- `busy` out 1: divider running
- `no_pulse` out 1: timeout flag (see Configuration)

## Operation
- Main FSM states: S_WAIT_FIRST, S_TRACK.
  - Reset enters S_WAIT_FIRST.
  - In S_WAIT_FIRST, a peak clears the counter and moves to S_TRACK. No interval is recorded.
- Interval counter `cnt`:
  - Increments on each `valid_in` while `en` is high.
  - Saturates at 2^CNT_W-1.
- Peak in S_TRACK with cnt < MIN_INTERVAL: rejected. Counter and history are unchanged.
- Peak in S_TRACK with cnt >= MIN_INTERVAL: accepted.
  - cnt is pushed into the N-entry ring buffer, and the running sum is updated (subtract oldest, add new).
  - cnt reloads to 0, or to 1 if `valid_in` is high in the same cycle.
- Fill counter:
  - No division is started until N intervals are held.
  - It is cleared on reset and on timeout.
- Once the buffer is full, each accepted peak starts a division:
  - avg = sum >> AVG_LOG2, with sum width CNT_W+AVG_LOG2.
  - bpm = NUM / avg.
  - The quotient saturates to 2^BPM_W-1.
- Peak accepted while `busy`: the interval still enters the history, but no new division starts. `bpm_out` is updated only by the running division.
- `en` low:
  - Counter holds and peaks are ignored.
  - A running division completes normally.
- `rst` mid-division: the division aborts. All state and outputs return to reset values.
- Reset values: `bpm_out` 0, `bpm_valid` 0, `busy` 0, `no_pulse` 0. Ring buffer, sum, fill counter and cnt are all 0.

## Timing
- Division is a restoring divider, one quotient bit per cycle over NUM_W = $clog2(NUM+1) bits (13 for the defaults).
- Edge E samples an accepting `peak_in`.
  - E+1: history and sum are updated.
  - E+2: divider loads avg, and `busy` rises.
  - `bpm_out`/`bpm_valid` are registered NUM_W+2 cycles after E (15 for the defaults).
  - `busy` falls in the same cycle that `bpm_valid` rises.
- `bpm_valid` is high for exactly one cycle and never while `rst` is high.
- `peak_in` is honoured on any cycle and does not need `valid_in`. A `peak_in` high for k cycles counts as k peaks; later ones are rejected by MIN_INTERVAL.

## Configuration
- `BPM_TIMEOUT_EN` defined:
  - When cnt reaches MAX_INTERVAL in S_TRACK, the FSM returns to S_WAIT_FIRST, and the history, sum and fill counter clear.
  - `no_pulse` is set. It clears on the next accepted interval.
  - `bpm_out` is forced to 0 with one `bpm_valid` strobe.
- `BPM_TIMEOUT_EN` undefined:
  - No timeout. cnt saturates and the history is kept.
  - `no_pulse` is tied to 0, and MAX_INTERVAL is unused.

## Structure
- Package `bpm_pkg` holds:
  - the FSM state enum for S_WAIT_FIRST/S_TRACK
  - the divider state enum for D_IDLE/D_RUN/D_DONE
  - a function computing NUM_W from FS
- Sub-module `bpm_seq_divider`: unsigned restoring divider with start/busy/done handshake, parameterised numerator and denominator widths, and output saturation.
- The ring buffer, sum, counter and FSM live in `bpm_calculator`.

## Test plan
- Defaults; 5 peaks spaced 100 valid strobes apart -> no `bpm_valid` for the first 4 peaks; `bpm_out`=75 and `bpm_valid` 15 cycles after the 5th.
- Intervals 100,100,120,80 -> avg 100, `bpm_out`=75; then one interval of 125 makes history 100,120,80,125, sum 425, avg 106 -> `bpm_out`=70.
- Extra peak 20 samples after an accepted peak -> rejected; the next peak at 100 samples from the accepted one yields the unchanged interval 100.
- With `BPM_TIMEOUT_EN`: no peak for 375 strobes -> `no_pulse`=1, `bpm_out`=0 with one strobe; 5 further peaks at 125 -> `bpm_out`=60, `no_pulse`=0.
- Peak accepted while `busy` -> no second `bpm_valid`; history includes the interval (checked via the next division result).
- `rst` asserted mid-division -> next cycle `busy`=0, `bpm_out`=0; no `bpm_valid` until 5 new peaks.
